// File: rtl/ap_ctrl_pkg.sv
// Shared types and default widths for the ap_ctrl sequencer.
package ap_ctrl_pkg;

  localparam int CNT_W_DEFAULT       = 16;
  localparam int LAT_W_DEFAULT       = 32;
  localparam int TIMEOUT_CYC_DEFAULT = 1000000;

  // Sequencer states: IDLE waits for a command, START drives ap_start,
  // WAIT_DONE holds one outstanding transaction, FINISH holds the result.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    FINISH    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  // Count enabled cycles; clear wins over enable, saturate at all-ones.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count_reg <= '0;
    end else if (en && !(&count_reg)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// Drives an HLS-style ap_start/ap_ready/ap_done kernel through a run of
// cfg_num_trans transactions, one outstanding at a time, and reports
// per-transaction latency and total run cycles.
// Optional feature: define SEQ_WATCHDOG_EN to add the timeout port and a
// per-transaction watchdog that aborts the run into FINISH.
module ap_ctrl_sequencer
  import ap_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int LAT_W       = LAT_W_DEFAULT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic [CNT_W-1:0] cfg_num_trans,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] trans_count,
  output logic [LAT_W-1:0] last_latency,
  output logic [LAT_W-1:0] max_latency,
  output logic [LAT_W-1:0] total_cycles
`ifdef SEQ_WATCHDOG_EN
  ,
  output logic             timeout
`endif
);

  // Counter slots in the generated counter bank.
  localparam int CNT_TXN   = 0;  // cycles spent in the current transaction
  localparam int CNT_TOTAL = 1;  // cycles spent busy in the current run

  seq_state_t       state_reg, state_next;
  logic [CNT_W-1:0] num_trans_reg;
  logic [CNT_W-1:0] trans_count_reg;
  logic [LAT_W-1:0] last_lat_reg;
  logic [LAT_W-1:0] max_lat_reg;
  logic [LAT_W-1:0] lat_now;
  logic [LAT_W-1:0] cnt_val [2];
  logic [1:0]       cnt_clr;
  logic [1:0]       cnt_en;
  logic             run_active;
  logic             start_acc;
  logic             done_evt;
  logic             done_ok;
  logic             last_txn;
  logic             wd_fire;

  assign run_active = (state_reg == START) || (state_reg == WAIT_DONE);
  assign start_acc  = cmd_start && ((state_reg == IDLE) || (state_reg == FINISH));
  // Ready and done together in START is a complete transaction.
  assign done_evt   = ((state_reg == START) && ap_ready && ap_done) ||
                      ((state_reg == WAIT_DONE) && ap_done);
  assign done_ok    = done_evt && !wd_fire;
  assign last_txn   = (trans_count_reg + CNT_W'(1)) == num_trans_reg;

  // The transaction counter reads 0 in the first START cycle, so the
  // inclusive latency in the done cycle is one more, saturated.
  assign lat_now = (&cnt_val[CNT_TXN]) ? cnt_val[CNT_TXN] : cnt_val[CNT_TXN] + LAT_W'(1);

`ifdef SEQ_WATCHDOG_EN
  localparam logic [LAT_W-1:0] WD_LIMIT = LAT_W'(TIMEOUT_CYC);
  logic timeout_reg;

  // Inclusive transaction latency has gone past the limit.
  assign wd_fire = run_active && (cnt_val[CNT_TXN] >= WD_LIMIT);

  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_reg <= 1'b0;
    end else if (wd_fire) begin
      timeout_reg <= 1'b1;
    end
  end

  assign timeout = timeout_reg;
`else
  assign wd_fire = 1'b0;
`endif

  assign cnt_clr[CNT_TXN]   = !run_active || done_ok;
  assign cnt_en[CNT_TXN]    = run_active;
  assign cnt_clr[CNT_TOTAL] = start_acc;
  assign cnt_en[CNT_TOTAL]  = run_active;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(.W(LAT_W)) u_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr[gi]),
        .en    (cnt_en[gi]),
        .count (cnt_val[gi])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; watchdog abort beats a coincident ap_done.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, FINISH: begin
        if (cmd_start) begin
          state_next = (cfg_num_trans == '0) ? FINISH : START;
        end
      end
      START: begin
        if (wd_fire) begin
          state_next = FINISH;
        end else if (ap_ready) begin
          if (ap_done) begin
            state_next = last_txn ? FINISH : START;
          end else begin
            state_next = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (wd_fire) begin
          state_next = FINISH;
        end else if (ap_done) begin
          state_next = last_txn ? FINISH : START;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Run bookkeeping: latch the count on a new run, tally completed transactions.
  always_ff @(posedge clock) begin
    if (reset) begin
      num_trans_reg   <= '0;
      trans_count_reg <= '0;
      last_lat_reg    <= '0;
      max_lat_reg     <= '0;
    end else if (start_acc) begin
      num_trans_reg   <= cfg_num_trans;
      trans_count_reg <= '0;
      last_lat_reg    <= '0;
      max_lat_reg     <= '0;
    end else if (done_ok) begin
      trans_count_reg <= trans_count_reg + CNT_W'(1);
      last_lat_reg    <= lat_now;
      if (lat_now > max_lat_reg) begin
        max_lat_reg <= lat_now;
      end
    end
  end

  assign ap_start     = (state_reg == START);
  assign busy         = run_active;
  assign finish       = (state_reg == FINISH);
  assign trans_count  = trans_count_reg;
  assign last_latency = last_lat_reg;
  assign max_latency  = max_lat_reg;
  assign total_cycles = cnt_val[CNT_TOTAL];

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Directed bench for ap_ctrl_sequencer. Inputs change and outputs are
// sampled on the falling clock edge. Built with or without SEQ_WATCHDOG_EN.
module tb_ap_ctrl_sequencer;

  localparam int CNT_W = 16;
  localparam int LAT_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             cmd_start;
  logic [CNT_W-1:0] cfg_num_trans;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             busy;
  logic             finish;
  logic [CNT_W-1:0] trans_count;
  logic [LAT_W-1:0] last_latency;
  logic [LAT_W-1:0] max_latency;
  logic [LAT_W-1:0] total_cycles;
`ifdef SEQ_WATCHDOG_EN
  logic             timeout;
`endif

  int checks = 0;
  int errors = 0;

  ap_ctrl_sequencer #(
    .CNT_W       (CNT_W),
    .LAT_W       (LAT_W),
    .TIMEOUT_CYC (10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_start     (cmd_start),
    .cfg_num_trans (cfg_num_trans),
    .ap_start      (ap_start),
    .ap_ready      (ap_ready),
    .ap_done       (ap_done),
    .busy          (busy),
    .finish        (finish),
    .trans_count   (trans_count),
    .last_latency  (last_latency),
    .max_latency   (max_latency),
    .total_cycles  (total_cycles)
`ifdef SEQ_WATCHDOG_EN
    ,
    .timeout       (timeout)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse cmd_start for one cycle with the given count.
  task automatic issue_cmd(input int n);
    cmd_start     = 1'b1;
    cfg_num_trans = CNT_W'(n);
    @(negedge clock);
    cmd_start     = 1'b0;
  endtask

  // Kernel model for one transaction: cycle 1 is the first START cycle,
  // ap_ready is high in cycle rdy, ap_done in cycle dn. Optionally pulse
  // cmd_start (count 7) in cycle cmd_at to probe mid-run commands.
  task automatic run_txn(input int rdy, input int dn, input int cmd_at);
    int c;
    for (int i = 0; i < 20 && ap_start !== 1'b1; i++) @(negedge clock);
    check("ap_start_seen", ap_start, 1);
    c = 1;
    while (c <= dn) begin
      ap_ready  = (c == rdy);
      ap_done   = (c == dn);
      cmd_start = (c == cmd_at);
      if (c == cmd_at) cfg_num_trans = CNT_W'(7);
      if (c == rdy) check("ap_start_held", ap_start, 1);
      if (c == rdy + 1) check("ap_start_drop", ap_start, 0);
      @(negedge clock);
      c++;
    end
    ap_ready  = 1'b0;
    ap_done   = 1'b0;
    cmd_start = 1'b0;
    $display("txn rdy=%0d done=%0d trans_count=%0d last_latency=%0d", rdy, dn, trans_count, last_latency);
  endtask

  initial begin
    reset         = 1'b1;
    cmd_start     = 1'b0;
    cfg_num_trans = '0;
    ap_ready      = 1'b0;
    ap_done       = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state
    check("rst_ap_start", ap_start, 0);
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    check("rst_trans_count", trans_count, 0);
    check("rst_total", total_cycles, 0);
`ifdef SEQ_WATCHDOG_EN
    check("rst_timeout", timeout, 0);
`endif

    // Zero-length run goes straight to FINISH
    issue_cmd(0);
    $display("zero run finish=%0d total=%0d", finish, total_cycles);
    check("zero_finish", finish, 1);
    check("zero_ap_start", ap_start, 0);
    check("zero_busy", busy, 0);
    check("zero_total", total_cycles, 0);
    repeat (3) @(negedge clock);
    check("zero_finish_held", finish, 1);

    // Three transactions, ready in cycle 2, done in cycle 5
    issue_cmd(3);
    run_txn(2, 5, 0);
    check("r3_tc_after1", trans_count, 1);
    check("r3_last_after1", last_latency, 5);
    check("r3_restart", ap_start, 1);
    run_txn(2, 5, 0);
    run_txn(2, 5, 0);
    check("r3_trans_count", trans_count, 3);
    check("r3_last", last_latency, 5);
    check("r3_max", max_latency, 5);
    check("r3_finish", finish, 1);
    check("r3_busy", busy, 0);
    check("r3_total", total_cycles, 15);

    // Ready and done together in the first START cycle; restarted from FINISH
    issue_cmd(2);
    check("r2_cleared_tc", trans_count, 0);
    check("r2_cleared_max", max_latency, 0);
    run_txn(1, 1, 0);
    check("r2_tc_after1", trans_count, 1);
    check("r2_busy_after1", busy, 1);
    run_txn(1, 1, 0);
    check("r2_trans_count", trans_count, 2);
    check("r2_last", last_latency, 1);
    check("r2_max", max_latency, 1);
    check("r2_finish", finish, 1);
    check("r2_total", total_cycles, 2);

    // cmd_start mid-run does not replace the latched count
    issue_cmd(2);
    run_txn(1, 3, 2);
    check("mid_busy", busy, 1);
    check("mid_tc", trans_count, 1);
    run_txn(1, 3, 0);
    check("mid_finish", finish, 1);
    check("mid_trans_count", trans_count, 2);
    check("mid_last", last_latency, 3);
    check("mid_total", total_cycles, 6);

    // Reset in WAIT_DONE aborts the run; a late ap_done is ignored
    issue_cmd(3);
    ap_ready = 1'b1;
    @(negedge clock);
    ap_ready = 1'b0;
    check("abort_in_wait", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset   = 1'b0;
    ap_done = 1'b1;
    @(negedge clock);
    ap_done = 1'b0;
    @(negedge clock);
    $display("abort busy=%0d finish=%0d trans_count=%0d", busy, finish, trans_count);
    check("abort_busy", busy, 0);
    check("abort_ap_start", ap_start, 0);
    check("abort_finish", finish, 0);
    check("abort_trans_count", trans_count, 0);
    check("abort_total", total_cycles, 0);
    check("abort_last", last_latency, 0);

`ifdef SEQ_WATCHDOG_EN
    // Watchdog: done withheld, fires after 11 cycles of the transaction
    issue_cmd(1);
    ap_ready = 1'b1;
    @(negedge clock);
    ap_ready = 1'b0;
    repeat (9) @(negedge clock);
    check("wd_cycle11_busy", busy, 1);
    check("wd_cycle11_timeout", timeout, 0);
    @(negedge clock);
    $display("watchdog timeout=%0d finish=%0d trans_count=%0d", timeout, finish, trans_count);
    check("wd_timeout", timeout, 1);
    check("wd_finish", finish, 1);
    check("wd_trans_count", trans_count, 0);
    check("wd_total", total_cycles, 11);
    ap_done = 1'b1;
    @(negedge clock);
    ap_done = 1'b0;
    check("wd_done_ignored", trans_count, 0);
    check("wd_sticky", timeout, 1);
`else
    // No watchdog: a long transaction is waited out and latency saturates
    issue_cmd(1);
    run_txn(1, 300, 0);
    check("long_finish", finish, 1);
    check("long_trans_count", trans_count, 1);
    check("long_last_sat", last_latency, 255);
    check("long_max_sat", max_latency, 255);
    check("long_total_sat", total_cycles, 255);
    ap_done = 1'b1;
    @(negedge clock);
    ap_done = 1'b0;
    check("long_done_ignored", trans_count, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
